// File: rtl/ser2par_rx.sv
// Bit-serial to parallel receiver: steers accepted bits into an N-bit word and
// presents completed words on a registered valid/ready port. Optional parity: SER2PAR_PARITY_CHECK_EN.
module ser2par_rx #(
    parameter int N         = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         ser_in,
    input  logic         ser_valid,
    output logic         ser_ready,
    output logic [N-1:0] par_out,
    output logic         par_valid,
    input  logic         par_ready,
    output logic         busy,
    output logic         parity_err
);
    localparam int CW = $clog2(N);

`ifdef SER2PAR_PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, COLLECT, PARITY, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    asm_q, asm_d;
    logic [N-1:0]    out_q, out_d;
    logic            pv_q, pv_d;
    logic            perr_q, perr_d;
    logic            hperr_q, hperr_d;

    logic            accept;
    logic            consume;
    logic            complete;
    logic            cmp_perr;
    logic [CW-1:0]   idx;

    assign ser_ready  = (state_q != HOLD);
    assign busy       = (state_q != IDLE);
    assign par_out    = out_q;
    assign par_valid  = pv_q;
    assign parity_err = perr_q;

    assign accept  = ser_valid && ser_ready && !clear;
    assign consume = pv_q && par_ready;
    assign idx     = LSB_FIRST ? cnt_q : (CW'(N - 1) - cnt_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        out_d    = out_q;
        pv_d     = pv_q;
        perr_d   = perr_q;
        hperr_d  = hperr_q;
        complete = 1'b0;
        cmp_perr = 1'b0;

        if (consume)
            pv_d = 1'b0;

        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, COLLECT: begin
                    if (accept) begin
                        asm_d[idx] = ser_in;
                        if (cnt_q == CW'(N - 1)) begin
                            cnt_d = '0;
`ifdef SER2PAR_PARITY_CHECK_EN
                            state_d = PARITY;
`else
                            complete = 1'b1;
`endif
                        end else begin
                            cnt_d   = cnt_q + CW'(1);
                            state_d = COLLECT;
                        end
                    end
                end
`ifdef SER2PAR_PARITY_CHECK_EN
                PARITY: begin
                    if (accept) begin
                        complete = 1'b1;
                        cmp_perr = (^asm_q) ^ ser_in;
                    end
                end
`endif
                HOLD: begin
                    // Held word moves out exactly when the current one is consumed
                    if (consume) begin
                        out_d   = asm_q;
                        pv_d    = 1'b1;
                        perr_d  = hperr_q;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (complete) begin
            if (!pv_q || par_ready) begin
                out_d   = asm_d;
                pv_d    = 1'b1;
                perr_d  = cmp_perr;
                state_d = IDLE;
            end else begin
                hperr_d = cmp_perr;
                state_d = HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
            out_q   <= '0;
            pv_q    <= 1'b0;
            perr_q  <= 1'b0;
            hperr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            out_q   <= out_d;
            pv_q    <= pv_d;
            perr_q  <= perr_d;
            hperr_q <= hperr_d;
        end
    end
endmodule
